patch_row_collector: RTL and testbench
======================================

Name: patch_row_collector

Overview:
- Sits directly downstream of the bank of N_REDUCER patch-row reducers and consumes their one-cycle done pulses.
- Each row result carries its patch_num, matcher_row, start_col and sum. The collector captures every result, arbitrates round-robin, and counts rows per patch.
- Non-final rows go back to the config dispatcher as a rechain request (next row, sum seeds conf_sum).
- Final rows (PATCH_SIZE-th result of a patch) are pushed into an output FIFO of completed patch sums.

Parameters:
- N_REDUCER, 4, number of upstream reducer lanes (>=1)
- N_PATCH, 64, number of patch IDs; count table depth
- PATCH_SIZE, 4, rows per patch (>=2)
- N_ROW_SIZE, 11, row field width
- N_COL_SIZE, 11, column field width
- FP_SIZE, 32, floating-point sum width (opaque bits, no arithmetic)
- FIFO_DEPTH, 8, result FIFO entries (power of 2)
- DELAY, 1, simulation #delay on registered assignments

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of holds, stage, count table, FIFO, err
- red_done  in  N_REDUCER  per-lane done pulse from reducer
- red_patch_num  in  N_REDUCER*log2(N_PATCH)  lane i at [i*W+:W]
- red_row  in  N_REDUCER*N_ROW_SIZE  lane matcher_row
- red_col  in  N_REDUCER*N_COL_SIZE  lane start_col
- red_sum  in  N_REDUCER*FP_SIZE  lane sum
- rechain_valid  out  1  non-final row result available
- rechain_ready  in  1  dispatcher accepts rechain
- rechain_patch_num  out  log2(N_PATCH)  patch ID
- rechain_row  out  N_ROW_SIZE  row+1, modulo 2^N_ROW_SIZE
- rechain_col  out  N_COL_SIZE  unchanged start_col
- rechain_sum  out  FP_SIZE  partial sum (next conf_sum)
- rechain_lane  out  log2(N_REDUCER)  originating lane (now free)
- result_valid  out  1  FIFO non-empty, first-word-fall-through
- result_ready  in  1  pop
- result_patch_num  out  log2(N_PATCH)  completed patch ID
- result_sum  out  FP_SIZE  final patch sum
- err_overflow  out  1  sticky: done arrived on an occupied lane hold

Behaviour:
- Reset (RESET_N low, async): holds empty, stage empty, count table all 0, FIFO empty, rr pointer 0. All outputs are 0: rechain_valid, result_valid, err_overflow, and all data outputs.
- flush: same clearing as reset, taken at the next edge. Takes priority over every other update that cycle.
- Capture: red_done[i] high in cycle c loads hold[i] at the end of c, so hold_valid[i] is set in c+1.
  - If hold_valid[i] is already set and is not being granted in that same cycle, keep the old entry, drop the new one, and set err_overflow.
  - A grant and a new capture on the same lane in the same cycle is legal: the hold is reloaded.
- Arbiter: round-robin over hold_valid, starting from the lane after the last grant. It grants at most one lane per cycle, only when the stage is empty or empties this cycle.
- Grant action, same edge:
  - Read count[patch]. If it equals PATCH_SIZE-1, set final=1 and write count to 0; otherwise set final=0 and write count+1.
  - Load the stage and clear hold_valid for the granted lane.
  - Back-to-back grants for the same patch see the updated count; no read-after-write hazard is allowed.
- Stage, non-final: rechain_valid = stage_valid & ~final. Outputs are stable until the rechain_valid&rechain_ready handshake; the stage empties on that handshake.
- Stage, final: pushes into the FIFO at the edge when the FIFO is not full, then the stage empties. If the FIFO is full, the stage holds and the arbiter stalls.
- Latency with no backpressure:
  - done in cycle c gives rechain_valid in c+2.
  - A final result gives result_valid in c+3.
- Drain: a simultaneous FIFO push and pop when full is allowed and keeps the count constant.
- Row wrap: rechain_row = red_row+1 truncated (all-ones wraps to 0), with no error raised.
- No arithmetic on sum; bits pass through.

Test Plan:
- Single lane, PATCH_SIZE=4, patch 5: four done pulses with row 10,11,12,13 and sums 0x3F800000..0x40800000.
  - Rows 10..12 give rechain rows 11,12,13 with the matching sums, each at c+2.
  - The fourth gives result_patch_num=5, result_sum=0x40800000 at c+3, with count[5] back to 0.
- All 4 lanes pulse done in the same cycle with patches 1,2,3,4 and rechain_ready=1: grants in order lanes 0,1,2,3 on consecutive cycles. The next simultaneous burst starts from lane 0 again after wrap, with no loss.
- rechain_ready=0 for 10 cycles while lanes 0 and 1 are pending:
  - The stage holds with stable outputs and no further grants.
  - A new done on lane 0 while its hold is full sets err_overflow=1.
  - After ready is raised, the lane-1 result emerges.
- FIFO_DEPTH=8 with result_ready=0: complete 9 patches. Eight go to the FIFO, the ninth stalls in the stage. One pop lets it enter the next cycle, and order is preserved.
- red_row=0x7FF non-final gives rechain_row=0x000.
- Async reset asserted mid-stream gives all outputs 0 immediately.
- flush with pending work clears count[] so a subsequent row of the same patch is treated as the first row.

Source files
------------

// File: rtl/patch_row_collector_if.sv
// Bus bundle for patch_row_collector.
//   Reducer side : flush, red_done/red_patch_num/red_row/red_col/red_sum
//                  (per-lane packed, lane i at index i).
//   Rechain side : rechain_valid/ready + patch_num, row, col, sum, lane.
//   Result side  : result_valid/ready + patch_num, sum (FWFT FIFO head).
//   Status       : err_overflow (sticky).
// master = the collector, slave = the surrounding reducer/dispatcher/sink.
interface patch_row_collector_if #(
    parameter int N_REDUCER  = 4,
    parameter int N_PATCH    = 64,
    parameter int N_ROW_SIZE = 11,
    parameter int N_COL_SIZE = 11,
    parameter int FP_SIZE    = 32
);
    localparam int PW = (N_PATCH > 1) ? $clog2(N_PATCH) : 1;
    localparam int LW = (N_REDUCER > 1) ? $clog2(N_REDUCER) : 1;

    logic                                  flush;
    logic [N_REDUCER-1:0]                  red_done;
    logic [N_REDUCER-1:0][PW-1:0]          red_patch_num;
    logic [N_REDUCER-1:0][N_ROW_SIZE-1:0]  red_row;
    logic [N_REDUCER-1:0][N_COL_SIZE-1:0]  red_col;
    logic [N_REDUCER-1:0][FP_SIZE-1:0]     red_sum;

    logic                   rechain_valid;
    logic                   rechain_ready;
    logic [PW-1:0]          rechain_patch_num;
    logic [N_ROW_SIZE-1:0]  rechain_row;
    logic [N_COL_SIZE-1:0]  rechain_col;
    logic [FP_SIZE-1:0]     rechain_sum;
    logic [LW-1:0]          rechain_lane;

    logic                   result_valid;
    logic                   result_ready;
    logic [PW-1:0]          result_patch_num;
    logic [FP_SIZE-1:0]     result_sum;

    logic                   err_overflow;

    modport master (
        input  flush, red_done, red_patch_num, red_row, red_col, red_sum,
        input  rechain_ready, result_ready,
        output rechain_valid, rechain_patch_num, rechain_row, rechain_col,
               rechain_sum, rechain_lane,
        output result_valid, result_patch_num, result_sum, err_overflow
    );

    modport slave (
        output flush, red_done, red_patch_num, red_row, red_col, red_sum,
        output rechain_ready, result_ready,
        input  rechain_valid, rechain_patch_num, rechain_row, rechain_col,
               rechain_sum, rechain_lane,
        input  result_valid, result_patch_num, result_sum, err_overflow
    );
endinterface

// File: rtl/patch_row_collector.sv
// patch_row_collector: captures per-lane reducer done pulses into one-entry
// holds, arbitrates round-robin into a single stage, counts rows per patch,
// and routes non-final rows back as rechain requests and final rows into a
// FWFT FIFO of completed patch sums.
//   CLK      : rising-edge clock
//   RESET_N  : async active-low reset
//   bus      : patch_row_collector_if.master (reducer in, rechain out,
//              result out, err_overflow)

// One-entry capture register per reducer lane.
module prc_lane_hold #(
    parameter int EW = 8
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          flush,
    input  logic          done,
    input  logic          gnt,
    input  logic [EW-1:0] din,
    output logic          vld,
    output logic [EW-1:0] q,
    output logic          ovf
);
    logic load;

    // A grant frees the entry on the same edge, so a same-cycle done may reload it.
    assign load = done & (~vld | gnt);
    assign ovf  = done & vld & ~gnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else begin
            if (load) q <= din;
            vld <= load | (vld & ~gnt);
        end
    end
endmodule

module patch_row_collector #(
    parameter int N_REDUCER  = 4,
    parameter int N_PATCH    = 64,
    parameter int PATCH_SIZE = 4,
    parameter int N_ROW_SIZE = 11,
    parameter int N_COL_SIZE = 11,
    parameter int FP_SIZE    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input logic                   CLK,
    input logic                   RESET_N,
    patch_row_collector_if.master bus
);
    localparam int PW   = (N_PATCH > 1) ? $clog2(N_PATCH) : 1;
    localparam int LW   = (N_REDUCER > 1) ? $clog2(N_REDUCER) : 1;
    localparam int CW   = $clog2(PATCH_SIZE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PTRW = AW + 1;
    localparam int EW   = PW + N_ROW_SIZE + N_COL_SIZE + FP_SIZE;
    localparam int RW   = PW + FP_SIZE;

    // ---------------- lane holds ----------------
    logic [N_REDUCER-1:0]         hold_vld;
    logic [N_REDUCER-1:0][EW-1:0] hold_q;
    logic [N_REDUCER-1:0]         ovf;
    logic [N_REDUCER-1:0]         gnt;

    for (genvar i = 0; i < N_REDUCER; i++) begin : g_lane
        prc_lane_hold #(.EW(EW)) u_hold (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .flush   (bus.flush),
            .done    (bus.red_done[i]),
            .gnt     (gnt[i]),
            .din     ({bus.red_patch_num[i], bus.red_row[i], bus.red_col[i], bus.red_sum[i]}),
            .vld     (hold_vld[i]),
            .q       (hold_q[i]),
            .ovf     (ovf[i])
        );
    end

    // ---------------- stage / FIFO state ----------------
    logic                  st_vld, st_final;
    logic [PW-1:0]         st_patch;
    logic [N_ROW_SIZE-1:0] st_row;
    logic [N_COL_SIZE-1:0] st_col;
    logic [FP_SIZE-1:0]    st_sum;
    logic [LW-1:0]         st_lane;

    logic [RW-1:0]   mem [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic            empty, full, push, pop, push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = ~empty & bus.result_ready;
    // When full, a same-edge pop makes room, so the count stays constant.
    assign push_ok = ~full | bus.result_ready;
    assign push    = st_vld & st_final & push_ok;

    logic stage_free;
    assign stage_free = ~st_vld
                      | (~st_final & bus.rechain_ready)
                      | (st_final & push_ok);

    // ---------------- round-robin arbiter ----------------
    logic [LW-1:0] rr_ptr;    // first lane to consider this cycle
    logic [LW-1:0] gnt_idx;
    logic          gnt_any;

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (stage_free) begin
            for (int k = 0; k < N_REDUCER; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_REDUCER) idx = idx - N_REDUCER;
                if (!gnt_any && hold_vld[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = LW'(idx);
                end
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    logic [PW-1:0]         s_patch;
    logic [N_ROW_SIZE-1:0] s_row;
    logic [N_COL_SIZE-1:0] s_col;
    logic [FP_SIZE-1:0]    s_sum;
    assign {s_patch, s_row, s_col, s_sum} = hold_q[gnt_idx];

    // ---------------- per-patch row count ----------------
    // Plain flop table: a grant on the next cycle reads the value written
    // by this grant, so back-to-back rows of one patch need no bypass.
    logic [CW-1:0] cnt [N_PATCH];
    logic [CW-1:0] cur;
    logic          is_final;
    assign cur      = cnt[s_patch];
    assign is_final = (cur == CW'(PATCH_SIZE - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int p = 0; p < N_PATCH; p++) cnt[p] <= '0;
        end else if (bus.flush) begin
            for (int p = 0; p < N_PATCH; p++) cnt[p] <= '0;
        end else if (gnt_any) begin
            cnt[s_patch] <= is_final ? '0 : cur + CW'(1);
        end
    end

    // ---------------- stage + rr pointer ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st_vld   <= 1'b0;
            st_final <= 1'b0;
            st_patch <= '0;
            st_row   <= '0;
            st_col   <= '0;
            st_sum   <= '0;
            st_lane  <= '0;
            rr_ptr   <= '0;
        end else if (bus.flush) begin
            st_vld   <= 1'b0;
            st_final <= 1'b0;
            rr_ptr   <= '0;
        end else if (gnt_any) begin
            st_vld   <= 1'b1;
            st_final <= is_final;
            st_patch <= s_patch;
            st_row   <= s_row + N_ROW_SIZE'(1);   // wraps silently
            st_col   <= s_col;
            st_sum   <= s_sum;
            st_lane  <= gnt_idx;
            rr_ptr   <= (gnt_idx == LW'(N_REDUCER - 1)) ? '0 : gnt_idx + LW'(1);
        end else if (stage_free) begin
            st_vld   <= 1'b0;
        end
    end

    // ---------------- result FIFO ----------------
    always_ff @(posedge CLK) begin
        if (push && !bus.flush) mem[wr_ptr[AW-1:0]] <= {st_patch, st_sum};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
        end
    end

    // ---------------- sticky overflow ----------------
    logic err_q;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)       err_q <= 1'b0;
        else if (bus.flush) err_q <= 1'b0;
        else if (|ovf)      err_q <= 1'b1;
    end

    // ---------------- outputs (data zeroed when not valid) ----------------
    logic [RW-1:0] head;
    assign head = mem[rd_ptr[AW-1:0]];

    assign bus.rechain_valid     = st_vld & ~st_final;
    assign bus.rechain_patch_num = bus.rechain_valid ? st_patch : '0;
    assign bus.rechain_row       = bus.rechain_valid ? st_row   : '0;
    assign bus.rechain_col       = bus.rechain_valid ? st_col   : '0;
    assign bus.rechain_sum       = bus.rechain_valid ? st_sum   : '0;
    assign bus.rechain_lane      = bus.rechain_valid ? st_lane  : '0;

    assign bus.result_valid      = ~empty;
    assign bus.result_patch_num  = empty ? '0 : head[RW-1:FP_SIZE];
    assign bus.result_sum        = empty ? '0 : head[FP_SIZE-1:0];

    assign bus.err_overflow      = err_q;
endmodule

// File: tb/tb_patch_row_collector.sv
module tb_patch_row_collector;
    localparam int NR = 4, NP = 64, PS = 4, RW = 11, CLW = 11, FP = 32, FD = 8;
    localparam int PW = 6, LW = 2;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    patch_row_collector_if #(.N_REDUCER(NR), .N_PATCH(NP), .N_ROW_SIZE(RW),
                             .N_COL_SIZE(CLW), .FP_SIZE(FP)) bus ();

    patch_row_collector #(.N_REDUCER(NR), .N_PATCH(NP), .PATCH_SIZE(PS),
                          .N_ROW_SIZE(RW), .N_COL_SIZE(CLW), .FP_SIZE(FP),
                          .FIFO_DEPTH(FD)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_rc[$];
    logic [127:0] exp_res[$];
    int cnt [NP];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rc_pack(input int p, input int r, input int c,
                                             input logic [31:0] s, input int l);
        logic [PW+RW+CLW+FP+LW-1:0] v;
        v = {PW'(p), RW'(r), CLW'(c), s, LW'(l)};
        return 128'(v);
    endfunction

    function automatic logic [127:0] res_pack(input int p, input logic [31:0] s);
        logic [PW+FP-1:0] v;
        v = {PW'(p), s};
        return 128'(v);
    endfunction

    function automatic logic [127:0] rc_obs();
        return 128'({bus.rechain_patch_num, bus.rechain_row, bus.rechain_col,
                     bus.rechain_sum, bus.rechain_lane});
    endfunction

    function automatic logic [127:0] res_obs();
        return 128'({bus.result_patch_num, bus.result_sum});
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        exp_rc.delete();
        exp_res.delete();
    endtask

    // Drive one lane's done plus data; track=1 updates the scoreboard model.
    task automatic arm(input int lane, input int p, input int r, input int c,
                       input logic [31:0] s, input bit track);
        bus.red_done[lane]      = 1'b1;
        bus.red_patch_num[lane] = PW'(p);
        bus.red_row[lane]       = RW'(r);
        bus.red_col[lane]       = CLW'(c);
        bus.red_sum[lane]       = s;
        if (track) begin
            if (cnt[p] == PS - 1) begin
                cnt[p] = 0;
                exp_res.push_back(res_pack(p, s));
            end else begin
                cnt[p]++;
                exp_rc.push_back(rc_pack(p, r + 1, c, s, lane));
            end
        end
    endtask

    task automatic send(input int lane, input int p, input int r, input int c,
                        input logic [31:0] s, input bit track);
        tick();
        arm(lane, p, r, c, s, track);
        tick();
        bus.red_done = '0;
    endtask

    // Scoreboard monitor: compare every accepted handshake against the queues.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (bus.rechain_valid && bus.rechain_ready) begin
                if (exp_rc.size() == 0) chk("rc_unexp", bus.rechain_valid, 1'b0);
                else                    chk("rechain", rc_obs(), exp_rc.pop_front());
            end
            if (bus.result_valid && bus.result_ready) begin
                if (exp_res.size() == 0) chk("res_unexp", bus.result_valid, 1'b0);
                else                     chk("result", res_obs(), exp_res.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] s1 [4];

    initial begin
        bus.flush = 1'b0;
        bus.red_done = '0;
        bus.red_patch_num = '0;
        bus.red_row = '0;
        bus.red_col = '0;
        bus.red_sum = '0;
        bus.rechain_ready = 1'b1;
        bus.result_ready = 1'b1;
        model_reset();
        s1[0] = 32'h3F80_0000; s1[1] = 32'h4000_0000;
        s1[2] = 32'h4040_0000; s1[3] = 32'h4080_0000;

        // ---- reset state ----
        #1;
        chk("rst_rv",  bus.rechain_valid, 1'b0);
        chk("rst_qv",  bus.result_valid, 1'b0);
        chk("rst_err", bus.err_overflow, 1'b0);
        chk("rst_rcd", rc_obs(), 128'd0);
        chk("rst_qd",  res_obs(), 128'd0);
        idle(2);
        RESET_N = 1'b1;
        idle(2);

        // ---- T1: single lane, patch 5, latency ----
        for (int j = 0; j < 4; j++) begin
            send(0, 5, 10 + j, 7, s1[j], 1'b1);
            @(negedge CLK);
            chk("t1_c1_rv", bus.rechain_valid, 1'b0);
            chk("t1_c1_qv", bus.result_valid, 1'b0);
            @(negedge CLK);
            if (j < 3) chk("t1_c2_rv", bus.rechain_valid, 1'b1);
            else       chk("t1_c2_qv", bus.result_valid, 1'b0);
            if (j == 3) begin
                @(negedge CLK);
                chk("t1_c3_qv", bus.result_valid, 1'b1);
                chk("t1_c3_qd", res_obs(), res_pack(5, 32'h4080_0000));
            end
            idle(1);
        end
        // count[5] is back to 0: next row of patch 5 is non-final again
        send(0, 5, 20, 7, 32'h1111_0000, 1'b1);
        idle(3);
        // leave the pointer after lane 3 so the burst starts at lane 0
        send(3, 50, 1, 1, 32'h5050_5050, 1'b1);
        idle(4);

        // ---- T2: simultaneous bursts on all lanes ----
        for (int b = 0; b < 2; b++) begin
            tick();
            for (int l = 0; l < NR; l++) arm(l, l + 1, 100 * (b + 1) + l, l, 32'hB000_0000 + l, 1'b1);
            tick();
            bus.red_done = '0;
            @(negedge CLK);
            for (int l = 0; l < NR; l++) begin
                @(negedge CLK);
                chk("t2_gnt", {bus.rechain_valid, bus.rechain_lane}, {1'b1, LW'(l)});
            end
            idle(2);
        end

        // ---- T3: rechain backpressure and overflow ----
        chk("t3_err0", bus.err_overflow, 1'b0);
        bus.rechain_ready = 1'b0;
        tick();
        arm(0, 20, 1, 0, 32'hC000_0000, 1'b1);
        arm(1, 21, 1, 1, 32'hC000_0001, 1'b1);
        tick();
        bus.red_done = '0;
        send(0, 22, 2, 0, 32'hC000_0002, 1'b1);  // refills lane-0 hold
        @(negedge CLK);
        chk("t3_err1", bus.err_overflow, 1'b0);
        send(0, 23, 3, 0, 32'hDEAD_0000, 1'b0);  // lane-0 hold occupied: dropped
        @(negedge CLK);
        chk("t3_err2", bus.err_overflow, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            chk("t3_hold", {bus.rechain_valid, rc_obs()}, {1'b1, exp_rc[0]});
        end
        tick();
        bus.rechain_ready = 1'b1;
        idle(8);
        chk("t3_drain", exp_rc.size(), 0);

        // ---- T4: FIFO full, ninth final stalls in the stage ----
        bus.result_ready = 1'b0;
        for (int p = 0; p < 9; p++)
            for (int r = 0; r < 4; r++) begin
                send(2, 30 + p, r, p, {16'hA000, 8'(p), 8'(r)}, 1'b1);
                idle(2);
            end
        idle(3);
        chk("t4_qv", bus.result_valid, 1'b1);
        chk("t4_head", res_obs(), exp_res[0]);
        send(1, 45, 5, 0, 32'h1234_5678, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("t4_stall", bus.rechain_valid, 1'b0);
        end
        tick();
        bus.result_ready = 1'b1;
        idle(20);
        chk("t4_res_drain", exp_res.size(), 0);
        chk("t4_rc_drain", exp_rc.size(), 0);

        // ---- T5: row wrap ----
        send(1, 9, 11'h7FF, 3, 32'hDEAD_BEEF, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        chk("t5_wrap", {bus.rechain_valid, bus.rechain_row}, {1'b1, 11'h000});
        idle(3);

        // ---- T6: flush with pending work ----
        bus.rechain_ready = 1'b0;
        send(0, 7, 1, 1, 32'h0000_0077, 1'b1);
        idle(2);
        chk("t6_pend", bus.rechain_valid, 1'b1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("t6_rv", bus.rechain_valid, 1'b0);
        chk("t6_err", bus.err_overflow, 1'b0);
        bus.rechain_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            send(0, 7, 40 + r, 2, 32'h7700_0000 + r, 1'b1);
            idle(2);
        end
        idle(4);
        chk("t6_res", exp_res.size(), 0);

        // ---- T7: async reset mid-stream ----
        bus.result_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            send(0, 12, r, 0, 32'h1200_0000 + r, 1'b1);
            idle(2);
        end
        bus.rechain_ready = 1'b0;
        send(1, 13, 0, 0, 32'h1300_0000, 1'b1);
        idle(2);
        chk("t7_pre_rv", bus.rechain_valid, 1'b1);
        chk("t7_pre_qv", bus.result_valid, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t7_rv",  bus.rechain_valid, 1'b0);
        chk("t7_qv",  bus.result_valid, 1'b0);
        chk("t7_err", bus.err_overflow, 1'b0);
        chk("t7_data", {rc_obs(), res_obs()}, 128'd0);
        model_reset();
        idle(2);
        RESET_N = 1'b1;
        bus.rechain_ready = 1'b1;
        bus.result_ready = 1'b1;
        send(2, 14, 3, 3, 32'h1400_0000, 1'b1);

        // ---- final drain, bounded ----
        for (int k = 0; k < 200 && (exp_rc.size() != 0 || exp_res.size() != 0); k++) tick();
        chk("end_rc", exp_rc.size(), 0);
        chk("end_res", exp_res.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
